trng_word_packer: RTL and testbench

Parametrised successor to the TRNG bit collector. Packs qualified random bits from the entropy core into WORD_W-bit words and buffers them in a small synchronous FIFO. Words leave through a valid/ready stream to the UART/AXI readout path. Adds a bit-valid qualifier, back-pressure, a flush control, overflow accounting and optional Von Neumann debiasing.

---
 rtl/trng_word_packer.sv | 114 +++++++++++
 tb/tb_trng_word_packer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/trng_word_packer.sv
// trng_word_packer: packs qualified random bits into WORD_W-bit words behind a small FIFO.
// Optional Von Neumann debiasing is enabled by defining TRNG_VN_DEBIAS_EN.
module trng_word_packer #(
    parameter int WORD_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int MSB_FIRST  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          bit_in,
    input  logic                          bit_valid,
    input  logic                          flush,
    output logic [WORD_W-1:0]             m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   overflow_cnt,
    output logic [$clog2(WORD_W):0]       bit_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(WORD_W) + 1;
    localparam logic [CW-1:0] LAST = CW'(WORD_W - 1);
    localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);

    logic              acc;
    logic              acc_bit;
    logic [WORD_W-1:0] sr_q, sr_d, sr_sh;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0]     lvl_q, lvl_d;
    logic [15:0]       ovf_q, ovf_d;
    logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
    logic              push, pop, full, wr_en;

`ifdef TRNG_VN_DEBIAS_EN
    logic half_q, first_q, vn_v_q, vn_b_q;

    // Pair raw samples; a 01/10 pair yields its first bit one cycle after the second sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            half_q  <= 1'b0;
            first_q <= 1'b0;
            vn_v_q  <= 1'b0;
            vn_b_q  <= 1'b0;
        end else if (flush) begin
            half_q <= 1'b0;
            vn_v_q <= 1'b0;
        end else begin
            vn_v_q <= bit_valid && half_q && (first_q != bit_in);
            vn_b_q <= first_q;
            if (bit_valid) begin
                half_q <= !half_q;
                if (!half_q) first_q <= bit_in;
            end
        end
    end

    assign acc     = vn_v_q && !flush;
    assign acc_bit = vn_b_q;
`else
    assign acc     = bit_valid && !flush;
    assign acc_bit = bit_in;
`endif

    // Next-state for packer, FIFO pointers, level and overflow counter
    always_comb begin
        sr_sh = (MSB_FIRST != 0) ? {sr_q[WORD_W-2:0], acc_bit} : {acc_bit, sr_q[WORD_W-1:1]};
        push  = acc && (cnt_q == LAST);
        pop   = (lvl_q != '0) && m_ready;
        full  = lvl_q == FULL;
        wr_en = push && (!full || pop);
        sr_d  = (flush || push) ? '0 : acc ? sr_sh : sr_q;
        cnt_d = (flush || push) ? '0 : acc ? cnt_q + CW'(1) : cnt_q;
        wr_d  = wr_en ? wr_q + 1'b1 : wr_q;
        rd_d  = pop ? rd_q + 1'b1 : rd_q;
        lvl_d = lvl_q + LW'(wr_en) - LW'(pop);
        ovf_d = (push && !wr_en && ovf_q != 16'hFFFF) ? ovf_q + 16'd1 : ovf_q;
    end

    // Control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
            ovf_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            lvl_q <= lvl_d;
            ovf_q <= ovf_d;
        end
    end

    // Word storage, cleared on reset so the head word reads 0 out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[wr_q] <= sr_sh;
        end
    end

    assign m_data       = mem_q[rd_q];
    assign m_valid      = lvl_q != '0;
    assign fifo_level   = lvl_q;
    assign overflow_cnt = ovf_q;
    assign bit_count    = cnt_q;
endmodule

// File: tb/tb_trng_word_packer.sv
// tb_trng_word_packer: directed tests for trng_word_packer (MSB-first and LSB-first instances).
module tb_trng_word_packer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic        flush = 1'b0;
    logic        m_ready = 1'b0;
    logic [31:0] m_data, l_data;
    logic        m_valid, l_valid;
    logic [2:0]  fifo_level, l_level;
    logic [15:0] overflow_cnt, l_ovf;
    logic [5:0]  bit_count, l_count;
    int checks = 0;
    int errors = 0;

    trng_word_packer #(.WORD_W(32), .FIFO_DEPTH(4), .MSB_FIRST(1)) dut (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .flush(flush),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .fifo_level(fifo_level), .overflow_cnt(overflow_cnt), .bit_count(bit_count)
    );

    trng_word_packer #(.WORD_W(32), .FIFO_DEPTH(4), .MSB_FIRST(0)) dut_l (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .flush(flush),
        .m_data(l_data), .m_valid(l_valid), .m_ready(m_ready),
        .fifo_level(l_level), .overflow_cnt(l_ovf), .bit_count(l_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        bit_in = b;
        tick();
        bit_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 31; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        flush = 1'b0;
        bit_valid = 1'b0;
        m_ready = 1'b0;
        #3;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        tick();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", m_valid); end
        checks++; if (m_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", m_data); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        checks++; if (overflow_cnt !== 16'd0) begin errors++; $display("FAIL reset_ovf: got %0d want 0", overflow_cnt); end
        checks++; if (bit_count !== 6'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bit_count); end
        rst = 1'b0;
    endtask

    task automatic test_stream;
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 31; i++) send_bit(i % 2 == 0);
        checks++; if (bit_count !== 6'd31) begin errors++; $display("FAIL stream_count31: got %0d want 31", bit_count); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL stream_early_valid: got %b want 0", m_valid); end
        send_bit(1'b0);
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL stream_valid: got %b want 1", m_valid); end
        checks++; if (m_data !== 32'hAAAAAAAA) begin errors++; $display("FAIL stream_msb_data: got %h want aaaaaaaa", m_data); end
        checks++; if (l_data !== 32'h55555555) begin errors++; $display("FAIL stream_lsb_data: got %h want 55555555", l_data); end
        checks++; if (bit_count !== 6'd0) begin errors++; $display("FAIL stream_count0: got %0d want 0", bit_count); end
        tick();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL stream_valid_fall: got %b want 0", m_valid); end
    endtask

    task automatic test_overflow;
        logic [31:0] w;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            w = 32'h11111111 * (k + 1);
            send_word(w);
        end
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level: got %0d want 4", fifo_level); end
        checks++; if (overflow_cnt !== 16'd2) begin errors++; $display("FAIL ovf_cnt: got %0d want 2", overflow_cnt); end
        checks++; if (bit_count !== 6'd0) begin errors++; $display("FAIL ovf_count: got %0d want 0", bit_count); end
        tick();
        tick();
        checks++; if (m_data !== 32'h11111111) begin errors++; $display("FAIL ovf_hold: got %h want 11111111", m_data); end
        m_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            w = 32'h11111111 * (k + 1);
            checks++; if (m_valid !== 1'b1 || m_data !== w) begin errors++; $display("FAIL ovf_pop%0d: got %b/%h want 1/%h", k, m_valid, m_data, w); end
            tick();
        end
        checks++; if (m_valid !== 1'b0 || fifo_level !== 3'd0) begin errors++; $display("FAIL ovf_drained: got %b/%0d want 0/0", m_valid, fifo_level); end
        tick();
        send_word(32'h77777777);
        checks++; if (m_valid !== 1'b1 || m_data !== 32'h77777777) begin errors++; $display("FAIL ovf_after_empty: got %b/%h want 1/77777777", m_valid, m_data); end
    endtask

    task automatic test_full_push_pop;
        logic [31:0] w;
        do_reset();
        for (int k = 0; k < 4; k++) send_word(32'hC0000000 + k);
        w = 32'hDEADBEEF;
        for (int i = 31; i >= 1; i--) send_bit(w[i]);
        m_ready = 1'b1;
        send_bit(w[0]);
        m_ready = 1'b0;
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL pp_level: got %0d want 4", fifo_level); end
        checks++; if (overflow_cnt !== 16'd0) begin errors++; $display("FAIL pp_ovf: got %0d want 0", overflow_cnt); end
        checks++; if (m_data !== 32'hC0000001) begin errors++; $display("FAIL pp_head: got %h want c0000001", m_data); end
        m_ready = 1'b1;
        tick();
        tick();
        tick();
        checks++; if (m_data !== 32'hDEADBEEF || fifo_level !== 3'd1) begin errors++; $display("FAIL pp_last: got %h/%0d want deadbeef/1", m_data, fifo_level); end
        m_ready = 1'b0;
    endtask

    task automatic test_flush;
        do_reset();
        for (int i = 0; i < 20; i++) send_bit(1'b0);
        checks++; if (bit_count !== 6'd20) begin errors++; $display("FAIL flush_count20: got %0d want 20", bit_count); end
        flush = 1'b1;
        bit_valid = 1'b1;
        bit_in = 1'b1;
        tick();
        flush = 1'b0;
        bit_valid = 1'b0;
        checks++; if (bit_count !== 6'd0) begin errors++; $display("FAIL flush_count0: got %0d want 0", bit_count); end
        for (int i = 0; i < 31; i++) send_bit(1'b1);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL flush_leak: got valid %b want 0", m_valid); end
        send_bit(1'b1);
        checks++; if (m_valid !== 1'b1 || m_data !== 32'hFFFFFFFF) begin errors++; $display("FAIL flush_word: got %b/%h want 1/ffffffff", m_valid, m_data); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (fifo_level !== 3'd1 || m_data !== 32'hFFFFFFFF) begin errors++; $display("FAIL flush_fifo_kept: got %0d/%h want 1/ffffffff", fifo_level, m_data); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        send_word(32'h12345678);
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        checks++; if (fifo_level !== 3'd1 || bit_count !== 6'd10) begin errors++; $display("FAIL rmid_pre: got %0d/%0d want 1/10", fifo_level, bit_count); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (m_valid !== 1'b0 || m_data !== 32'h0) begin errors++; $display("FAIL rmid_out: got %b/%h want 0/0", m_valid, m_data); end
        checks++; if (fifo_level !== 3'd0 || bit_count !== 6'd0) begin errors++; $display("FAIL rmid_cnt: got %0d/%0d want 0/0", fifo_level, bit_count); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_vn;
        logic [7:0] pat;
        logic [31:0] got;
        int seen;
        pat = 8'b01111000;
        seen = 0;
        got = '0;
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) send_bit(pat[7 - i]);
        checks++; if (bit_count !== 6'd2) begin errors++; $display("FAIL vn_count2: got %0d want 2", bit_count); end
        for (int g = 1; g < 16; g++) begin
            for (int i = 0; i < 8; i++) begin
                send_bit(pat[7 - i]);
                if (m_valid) begin seen++; got = m_data; end
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (m_valid) begin seen++; got = m_data; end
        end
        checks++; if (seen !== 1) begin errors++; $display("FAIL vn_words: got %0d want 1", seen); end
        checks++; if (got !== 32'h55555555) begin errors++; $display("FAIL vn_data: got %h want 55555555", got); end
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        checks++; if (bit_count !== 6'd1) begin errors++; $display("FAIL vn_count1: got %0d want 1", bit_count); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bit_count !== 6'd0 || m_valid !== 1'b0 || overflow_cnt !== 16'd0) begin errors++; $display("FAIL vn_rst: got %0d/%b/%0d want 0/0/0", bit_count, m_valid, overflow_cnt); end
        tick();
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
`ifdef TRNG_VN_DEBIAS_EN
        test_vn();
`else
        test_stream();
        test_overflow();
        test_full_push_pop();
        test_flush();
        test_reset_mid();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
